// File: rtl/stream_mux_pkg.sv
// Shared defaults and the select-width helper for the round-robin stream mux.
package stream_mux_pkg;

  localparam int DEFAULT_N_CH     = 4;
  localparam int DEFAULT_W        = 4;
  localparam int DEFAULT_PKT_LOCK = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin search starting after ptr, overridden by a held
// packet lock that pins the grant to one channel.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // w_cand[k] is the channel examined at search position k (ptr+1+k wrapped).
  logic [SEL_W-1:0] w_cand [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cand
      assign w_cand[gi] = SEL_W'((int'(ptr) + gi + 1) % N_CH);
    end
  endgenerate

  // Scan from the far end so the earliest search position wins.
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    if (lock_en) begin
      gnt_idx = lock_idx;
      gnt_any = req[lock_idx];
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (req[w_cand[k]]) begin
          gnt_idx = w_cand[k];
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration,
// optional packet locking and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int  N_CH     = DEFAULT_N_CH,
  parameter int  W        = DEFAULT_W,
  parameter int  PKT_LOCK = DEFAULT_PKT_LOCK,
  localparam int SEL_W    = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_sel
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;

  logic             w_load_en;
  logic             w_lock_en;
  logic             w_xfer;
  logic             w_gnt_any;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [W-1:0]     w_gnt_data;
  logic             w_gnt_last;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_lock_en = (PKT_LOCK != 0) && r_lock;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req      (in_valid),
    .ptr      (r_ptr),
    .lock_en  (w_lock_en),
    .lock_idx (r_lock_idx),
    .gnt_idx  (w_gnt_idx),
    .gnt_any  (w_gnt_any)
  );

  // gnt_any already implies the granted channel is valid.
  assign w_xfer     = !rst && w_load_en && w_gnt_any;
  assign w_gnt_data = in_data[w_gnt_idx*W +: W];
  assign w_gnt_last = in_last[w_gnt_idx];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = w_xfer && (w_gnt_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
      r_ptr       <= SEL_W'(N_CH - 1);
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
    end else begin
      if (w_load_en) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_gnt_data;
          r_out_last <= w_gnt_last;
          r_out_sel  <= w_gnt_idx;
        end
      end
      if (w_xfer) begin
        r_ptr <= w_gnt_idx;
        // A beat without last opens (or keeps) the lock; last releases it.
        if (PKT_LOCK != 0) begin
          r_lock     <= !w_gnt_last;
          r_lock_idx <= w_gnt_idx;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: per-channel beat sources, a cycle-level behavioural
// model checked on every negedge, and literal beat sequences per scenario.
module tb_stream_mux_rr;

  localparam int N_CH     = 4;
  localparam int W        = 4;
  localparam int PKT_LOCK = 1;
  localparam int SEL_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_CH-1:0]   in_valid = '0;
  logic [N_CH-1:0]   in_last = '0;
  logic [N_CH*W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [SEL_W-1:0]  out_sel;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .N_CH     (N_CH),
    .W        (W),
    .PKT_LOCK (PKT_LOCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  typedef struct {
    int ch;
    int data;
    int last;
  } beat_t;

  beat_t           src_q[$];
  beat_t           obs_q[$];
  int              obs_cyc[$];
  beat_t           exp_q[$];
  logic [N_CH-1:0] src_en = '1;
  logic [N_CH-1:0] src_fire = '0;

  function automatic int find_ch(input int ch);
    for (int k = 0; k < src_q.size(); k++)
      if (src_q[k].ch == ch) return k;
    return -1;
  endfunction

  function automatic int count_ch(input int ch);
    int n = 0;
    for (int k = 0; k < src_q.size(); k++)
      if (src_q[k].ch == ch) n++;
    return n;
  endfunction

  // Model state: the beat that must sit in the output register, the
  // round-robin pointer, and the locked channel (-1 when unlocked).
  bit m_valid;
  int m_data, m_last, m_sel;
  int m_ptr  = N_CH - 1;
  int m_lock = -1;

  initial begin : model_and_sources
    int g, c, idx;
    bit load_en, xfer;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
        m_ptr = N_CH - 1; m_lock = -1;
        src_q.delete();
        src_fire = '0;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_sel", int'(out_sel), 0);
        chk("rst in_ready", int'(in_ready), 0);
      end else begin
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) begin
          chk("out_data", int'(out_data), m_data);
          chk("out_last", int'(out_last), m_last);
          chk("out_sel", int'(out_sel), m_sel);
        end
        if (out_valid && out_ready) begin
          obs_q.push_back('{int'(out_sel), int'(out_data), int'(out_last)});
          obs_cyc.push_back(cyc);
        end
        load_en = !m_valid || out_ready;
        g = -1;
        if (m_lock >= 0) begin
          if (in_valid[m_lock]) g = m_lock;
        end else begin
          for (int k = 1; k <= N_CH; k++) begin
            c = (m_ptr + k) % N_CH;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
        xfer = load_en && (g >= 0);
        for (int i = 0; i < N_CH; i++)
          if (in_valid[i])
            chk($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(xfer && g == i));
        chk("in_ready onehot0", int'($onehot0(in_ready)), 1);
        if (!load_en) chk("in_ready stall", int'(in_ready), 0);
        src_fire = in_valid & in_ready;
        if (load_en) begin
          m_valid = xfer;
          if (xfer) begin
            m_data = int'(in_data[g*W +: W]);
            m_last = int'(in_last[g]);
            m_sel  = g;
          end
        end
        if (xfer) begin
          m_ptr = g;
          if (PKT_LOCK != 0) m_lock = in_last[g] ? -1 : g;
        end
      end
      @(posedge clk);
      #1;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (src_fire[ch]) begin
          idx = find_ch(ch);
          if (idx >= 0) src_q.delete(idx);
        end
      end
      for (int ch = 0; ch < N_CH; ch++) begin
        idx = find_ch(ch);
        in_valid[ch]        = src_en[ch] && (idx >= 0);
        in_data[ch*W +: W]  = (idx >= 0) ? W'(src_q[idx].data) : '0;
        in_last[ch]         = (idx >= 0) ? src_q[idx].last[0] : 1'b0;
      end
    end
  end

  task automatic push(input int ch, input int data, input int last);
    src_q.push_back('{ch, data, last});
  endtask

  task automatic expect_beat(input int ch, input int data, input int last);
    exp_q.push_back('{ch, data, last});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(src_q.size() == 0 && !out_valid && in_valid == '0) && n < 200) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk({name, " drain in budget"}, int'(n < 200), 1);
  endtask

  task automatic check_obs(input string name, input int base);
    chk({name, " beat count"}, obs_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++) begin
      chk($sformatf("%s beat%0d sel", name, k), obs_q[base+k].ch, exp_q[k].ch);
      chk($sformatf("%s beat%0d data", name, k), obs_q[base+k].data, exp_q[k].data);
      chk($sformatf("%s beat%0d last", name, k), obs_q[base+k].last, exp_q[k].last);
    end
    exp_q.delete();
  endtask

  initial begin : main
    int base, n;
    logic [W-1:0]     held_data;
    logic [SEL_W-1:0] held_sel;
    logic             held_last;

    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", int'(out_valid), 0);
    chk("async rst in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // All four channels valid: strict rotation from channel 0, one beat/cycle.
    base = obs_q.size();
    push(0, 10, 1); push(0, 10, 1); push(1, 11, 1); push(2, 12, 1); push(3, 13, 1);
    expect_beat(0, 10, 1); expect_beat(1, 11, 1); expect_beat(2, 12, 1);
    expect_beat(3, 13, 1); expect_beat(0, 10, 1);
    wait_drain("rotate");
    for (int k = 1; k < 5 && base + k < obs_cyc.size(); k++)
      chk($sformatf("rotate back-to-back %0d", k), obs_cyc[base+k] - obs_cyc[base], k);
    check_obs("rotate", base);

    // Lone channel 2 beat, then the output empties.
    base = obs_q.size();
    push(2, 5, 1);
    expect_beat(2, 5, 1);
    wait_drain("single ch2");
    chk("single ch2 idle out_valid", int'(out_valid), 0);
    check_obs("single ch2", base);

    // Move the pointer back to channel 0.
    base = obs_q.size();
    push(0, 7, 1);
    expect_beat(0, 7, 1);
    wait_drain("ptr to ch0");
    check_obs("ptr to ch0", base);

    // Packet lock: ch1's three beats stay together, then ch3, then ch0.
    base = obs_q.size();
    push(1, 1, 0); push(1, 2, 0); push(1, 3, 1); push(0, 8, 1); push(3, 9, 1);
    expect_beat(1, 1, 0); expect_beat(1, 2, 0); expect_beat(1, 3, 1);
    expect_beat(3, 9, 1); expect_beat(0, 8, 1);
    wait_drain("lock");
    check_obs("lock", base);

    // Locked ch1 goes idle mid-packet; ch0 must not slip in.
    base = obs_q.size();
    push(1, 1, 0); push(1, 2, 0); push(1, 3, 1); push(0, 4, 1);
    expect_beat(1, 1, 0); expect_beat(1, 2, 0); expect_beat(1, 3, 1); expect_beat(0, 4, 1);
    n = 0;
    while (count_ch(1) != 2 && n < 50) begin
      @(posedge clk); #3; n++;
    end
    chk("gap ch1 first beat taken", count_ch(1), 2);
    src_en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 src_en[1] = 1'b1;
    wait_drain("gap");
    check_obs("gap", base);

    // Downstream stall for four cycles with a beat held.
    base = obs_q.size();
    push(0, 1, 1); push(0, 2, 1); push(0, 3, 1);
    expect_beat(0, 1, 1); expect_beat(0, 2, 1); expect_beat(0, 3, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #3; n++;
    end
    chk("stall beat present", int'(out_valid), 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    #2;
    held_data = out_data;
    held_sel  = out_sel;
    held_last = out_last;
    repeat (4) begin
      @(negedge clk);
      chk("stall out_valid", int'(out_valid), 1);
      chk("stall out_data", int'(out_data), int'(held_data));
      chk("stall out_sel", int'(out_sel), int'(held_sel));
      chk("stall out_last", int'(out_last), int'(held_last));
      chk("stall in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("stall");
    check_obs("stall", base);

    // Reset in the middle of a locked ch2 packet.
    push(2, 5, 0); push(2, 6, 0); push(2, 7, 1);
    n = 0;
    while (count_ch(2) != 2 && n < 50) begin
      @(posedge clk); #3; n++;
    end
    chk("pre-rst out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst out_data", int'(out_data), 0);
    chk("mid rst out_sel", int'(out_sel), 0);
    chk("mid rst out_last", int'(out_last), 0);
    chk("mid rst in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    base = obs_q.size();
    push(0, 14, 1); push(2, 5, 1); push(3, 6, 1);
    expect_beat(0, 14, 1); expect_beat(2, 5, 1); expect_beat(3, 6, 1);
    wait_drain("after rst");
    check_obs("after rst", base);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, meaning the number of input channels (2..16).
REQ-002 The module SHALL have parameter W, default 4, meaning the data width per channel.
REQ-003 The module SHALL have parameter PKT_LOCK, default 1, meaning that when 1 a grant is held until a beat with last=1 transfers, and when 0 arbitration is per beat.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  N_CH  per-channel valid.
REQ-007 in_ready  output  N_CH  per-channel ready.
REQ-008 in_data  input  N_CH*W  channel i occupies bits [i*W +: W].
REQ-009 in_last  input  N_CH  per-channel end-of-packet marker.
REQ-010 out_valid  output  1  registered output holds a beat.
REQ-011 out_ready  input  1  downstream accepts a beat.
REQ-012 out_data  output  W  registered data.
REQ-013 out_last  output  1  registered last.
REQ-014 out_sel  output  SEL_W=max(1,$clog2(N_CH))  index of the source channel of the current out beat.

Function
REQ-015 A transfer on any port SHALL occur only in a cycle where valid and ready are both 1.
REQ-016 The output register SHALL load when load_en = !out_valid | out_ready.
REQ-017 in_ready[i] SHALL be 1 only when i equals the combinational grant and load_en is 1, so at most one in_ready bit is set.
REQ-018 When no lock is held, the grant SHALL be the first channel with in_valid=1, searching from (ptr+1) mod N_CH upward with wrap.
REQ-019 ptr SHALL update to the granted index on every input transfer.
REQ-020 With PKT_LOCK=1, a transfer with last=0 SHALL set lock to that channel.
REQ-021 While the lock is held, the grant SHALL be the locked channel only, even when that channel's in_valid is 0.
REQ-022 A transfer with last=1 from the locked channel SHALL clear the lock.
REQ-023 With PKT_LOCK=0, lock SHALL never be set.
REQ-024 Latency from input transfer to out_valid SHALL be 1 cycle.
REQ-025 Sustained throughput SHALL be 1 beat/cycle when out_ready=1 continuously.
REQ-026 When out_valid=1 and out_ready=0, out_data, out_last and out_sel SHALL hold stable and all in_ready SHALL be 0.
REQ-027 When no in_valid is set and load_en=1, out_valid SHALL go to 0 on the next edge and ptr SHALL remain unchanged.
REQ-028 A simultaneous drain and load SHALL replace the beat with no bubble.
REQ-029 If the locked channel drops in_valid mid-packet, the block SHALL stall and SHALL NOT grant any other channel.

Reset
REQ-030 On rst=1, out_valid SHALL be 0, out_data 0, out_last 0 and out_sel 0 immediately, without waiting for a clock edge.
REQ-031 On rst=1, ptr SHALL reset to N_CH-1 so that channel 0 wins first, and the lock SHALL be cleared.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet state, and the block SHALL NOT re-lock after release.
REQ-033 in_ready SHALL be 0 while rst=1.

Structure
REQ-034 Package stream_mux_pkg SHALL hold the SEL_W computation function and the default parameter constants.
REQ-035 Sub-module rr_arbiter (inputs: req[N_CH], ptr, lock_en, lock_idx; outputs: gnt_idx, gnt_any) SHALL contain the combinational round-robin search.
REQ-036 stream_mux_rr SHALL contain ptr, lock state, output register and ready logic.
REQ-037 No latches SHALL be inferred.
REQ-038 Every case statement SHALL have a default.

Verification
REQ-039 Reset release, ch0..3 all valid with data a,b,c,d, last=1, out_ready=1 -> out_data a,b,c,d on consecutive cycles, out_sel 0,1,2,3, then a again.
REQ-040 Only ch2 valid, data 5, last=1 -> out_data 5 one cycle later, out_sel=2, then out_valid=0 after in_valid drops.
REQ-041 PKT_LOCK=1, ch1 sends 3 beats (last on beat 3) while ch0 and ch3 are valid -> three ch1 beats contiguous, then ch3, then ch0.
REQ-042 out_ready=0 for 4 cycles with a beat held -> out_* stable, all in_ready=0; release -> no lost or duplicated beat.
REQ-043 Locked ch1 deasserts in_valid for 2 cycles mid-packet with ch0 valid -> no ch0 beat appears before the ch1 last beat.
REQ-044 rst pulsed mid-packet -> out_valid drops asynchronously; after release ch0 is granted first and no lock is held.
